// File: rtl/multi_clk_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_clk_divider: multi-channel programmable clock-enable divider with  |
// | shadowed period/high-time settings applied only at period boundaries.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multi_clk_divider #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div,
  input  logic [CHANNELS*WIDTH-1:0] high,
  output logic [CHANNELS-1:0]       clk_div,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_sdiv, w_sdiv_nxt;
    logic [WIDTH-1:0] r_shigh, w_shigh_nxt;
    logic [WIDTH-1:0] r_adiv, w_adiv_nxt;
    logic [WIDTH-1:0] r_ahigh, w_ahigh_nxt;
    logic             r_pending, w_pending_nxt;
    logic             r_clk_div, r_tick;
    logic [WIDTH-1:0] w_div_in, w_high_in, w_eff_div, w_eff_high;
    logic             w_run_nxt;

    assign w_div_in   = div[i*WIDTH +: WIDTH];
    assign w_high_in  = high[i*WIDTH +: WIDTH];
    // A load on the same edge as an apply point takes effect immediately.
    assign w_eff_div  = load[i] ? w_div_in  : r_sdiv;
    assign w_eff_high = load[i] ? w_high_in : r_shigh;

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_adiv_nxt    = r_adiv;
      w_ahigh_nxt   = r_ahigh;
      w_sdiv_nxt    = w_eff_div;
      w_shigh_nxt   = w_eff_high;
      w_pending_nxt = r_pending | load[i];
      case (r_state)
        ST_IDLE: begin
          if (en[i] && (w_eff_div != c_zero)) begin
            w_state_nxt   = ST_RUN;
            w_adiv_nxt    = w_eff_div;
            w_ahigh_nxt   = w_eff_high;
            w_cnt_nxt     = c_zero;
            w_pending_nxt = 1'b0;
          end
        end
        ST_RUN: begin
          if (!en[i]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = c_zero;
          end else if (r_cnt == r_adiv - c_one) begin
            w_cnt_nxt = c_zero;
            if (r_pending || load[i]) begin
              w_adiv_nxt    = w_eff_div;
              w_ahigh_nxt   = w_eff_high;
              w_pending_nxt = 1'b0;
              if (w_eff_div == c_zero) w_state_nxt = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    assign w_run_nxt = (w_state_nxt == ST_RUN);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state   <= ST_IDLE;
        r_cnt     <= c_zero;
        r_sdiv    <= c_zero;
        r_shigh   <= c_zero;
        r_adiv    <= c_zero;
        r_ahigh   <= c_zero;
        r_pending <= 1'b0;
        r_clk_div <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_sdiv    <= w_sdiv_nxt;
        r_shigh   <= w_shigh_nxt;
        r_adiv    <= w_adiv_nxt;
        r_ahigh   <= w_ahigh_nxt;
        r_pending <= w_pending_nxt;
        r_clk_div <= w_run_nxt && (w_cnt_nxt < w_ahigh_nxt);
        r_tick    <= w_run_nxt && (w_cnt_nxt == c_zero);
      end
    end

    assign clk_div[i] = r_clk_div;
    assign tick[i]    = r_tick;
    assign pending[i] = r_pending;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_clk_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multi_clk_divider: directed self-checking bench for multi_clk_divider |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multi_clk_divider;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] div;
  logic [CHANNELS*WIDTH-1:0] high;
  logic [CHANNELS-1:0]       clk_div;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       pending;

  int total;
  int bad;

  multi_clk_divider #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .div     (div),
    .high    (high),
    .clk_div (clk_div),
    .tick    (tick),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int d, input int h);
    div[ch*WIDTH +: WIDTH]  = WIDTH'(d);
    high[ch*WIDTH +: WIDTH] = WIDTH'(h);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = '0;
    load  = '0;
    div   = '0;
    high  = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = '1; load = '1; div = '1; high = '1;
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({tick, clk_div, pending} !== 12'h000) begin
      bad++;
      $display("FAIL reset t/c/p got=%h exp=000", {tick, clk_div, pending});
    end
    rst_n = 1'b1;
    en = '0; load = '0;
  endtask

  // div=5 high=2 on ch0
  task automatic test_basic();
    logic [9:0] ec, et;
    ec = 10'b1100011000;
    et = 10'b1000010000;
    do_reset();
    set_ch(0, 5, 2);
    load = 4'b0001; en = 4'b0001;
    step();
    load = '0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({tick[0], clk_div[0], pending[0]} !== {et[9-i], ec[9-i], 1'b0}) begin
        bad++;
        $display("FAIL basic cyc=%0d got t/c/p=%b%b%b exp=%b%b0", i,
                 tick[0], clk_div[0], pending[0], et[9-i], ec[9-i]);
      end
      step();
    end
  endtask

  // Running 5/2, load 3/1 while cnt=1
  task automatic test_midload();
    logic [9:0] ec, et, ep;
    ec = 10'b1100010010;
    et = 10'b1000010010;
    ep = 10'b0011100000;
    do_reset();
    set_ch(0, 5, 2);
    load = 4'b0001; en = 4'b0001;
    step();
    load = '0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({tick[0], clk_div[0], pending[0]} !== {et[9-i], ec[9-i], ep[9-i]}) begin
        bad++;
        $display("FAIL midload cyc=%0d got t/c/p=%b%b%b exp=%b%b%b", i,
                 tick[0], clk_div[0], pending[0], et[9-i], ec[9-i], ep[9-i]);
      end
      load = (i == 1) ? 4'b0001 : 4'b0000;
      if (i == 1) set_ch(0, 3, 1);
      step();
    end
    load = '0;
  endtask

  // Load 4/4 on the wrap edge (cnt=4) of a 5/2 period
  task automatic test_wrapload();
    logic [12:0] ec, et;
    ec = 13'b1100011111111;
    et = 13'b1000010001000;
    do_reset();
    set_ch(0, 5, 2);
    load = 4'b0001; en = 4'b0001;
    step();
    load = '0;
    for (int i = 0; i < 13; i++) begin
      total++;
      if ({tick[0], clk_div[0], pending[0]} !== {et[12-i], ec[12-i], 1'b0}) begin
        bad++;
        $display("FAIL wrapload cyc=%0d got t/c/p=%b%b%b exp=%b%b0", i,
                 tick[0], clk_div[0], pending[0], et[12-i], ec[12-i]);
      end
      load = (i == 4) ? 4'b0001 : 4'b0000;
      if (i == 4) set_ch(0, 4, 4);
      step();
    end
    load = '0;
  endtask

  task automatic test_edges();
    logic [7:0] et4;
    et4 = 8'b10001000;
    // div=1 high=1
    do_reset();
    set_ch(1, 1, 1);
    load = 4'b0010; en = 4'b0010;
    step();
    load = '0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({tick[1], clk_div[1], pending[1]} !== 3'b110) begin
        bad++;
        $display("FAIL div1 cyc=%0d got t/c/p=%b%b%b exp=110", i,
                 tick[1], clk_div[1], pending[1]);
      end
      step();
    end
    // div=4 high=0
    do_reset();
    set_ch(1, 4, 0);
    load = 4'b0010; en = 4'b0010;
    step();
    load = '0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({tick[1], clk_div[1], pending[1]} !== {et4[7-i], 2'b00}) begin
        bad++;
        $display("FAIL high0 cyc=%0d got t/c/p=%b%b%b exp=%b00", i,
                 tick[1], clk_div[1], pending[1], et4[7-i]);
      end
      step();
    end
    // div=0 from reset shadow: must stay idle
    do_reset();
    en = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({tick[1], clk_div[1], pending[1]} !== 3'b000) begin
        bad++;
        $display("FAIL div0 cyc=%0d got t/c/p=%b%b%b exp=000", i,
                 tick[1], clk_div[1], pending[1]);
      end
    end
    en = '0;
  endtask

  // Pending 3/1 retained across an en drop of 3 cycles
  task automatic test_en_drop();
    logic [9:0] ec, et, ep;
    ec = 10'b1100001001;
    et = 10'b1000001001;
    ep = 10'b0011110000;
    do_reset();
    set_ch(2, 5, 2);
    load = 4'b0100; en = 4'b0100;
    step();
    load = '0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({tick[2], clk_div[2], pending[2]} !== {et[9-i], ec[9-i], ep[9-i]}) begin
        bad++;
        $display("FAIL en_drop cyc=%0d got t/c/p=%b%b%b exp=%b%b%b", i,
                 tick[2], clk_div[2], pending[2], et[9-i], ec[9-i], ep[9-i]);
      end
      load = (i == 1) ? 4'b0100 : 4'b0000;
      if (i == 1) set_ch(2, 3, 1);
      if (i == 2) en = 4'b0000;
      if (i == 5) en = 4'b0100;
      step();
    end
    en = '0;
  endtask

  // ch0 2/1 and ch3 255/128 concurrently, then reset mid-period
  task automatic test_multi_reset();
    logic [3:0] exp_c, exp_t;
    do_reset();
    set_ch(0, 2, 1);
    set_ch(3, 255, 128);
    load = 4'b1001; en = 4'b1001;
    step();
    load = '0;
    for (int k = 0; k < 300; k++) begin
      exp_c = {((k % 255) < 128), 2'b00, ((k % 2) == 0)};
      exp_t = {((k % 255) == 0),  2'b00, ((k % 2) == 0)};
      total++;
      if ({tick, clk_div, pending} !== {exp_t, exp_c, 4'b0000}) begin
        bad++;
        $display("FAIL multi cyc=%0d got t/c/p=%b/%b/%b exp=%b/%b/0000", k,
                 tick, clk_div, pending, exp_t, exp_c);
      end
      step();
    end
    rst_n = 1'b0;
    load  = 4'b1001;
    step();
    total++;
    if ({tick, clk_div, pending} !== 12'h000) begin
      bad++;
      $display("FAIL multi_rst got t/c/p=%b/%b/%b exp=0000/0000/0000",
               tick, clk_div, pending);
    end
    rst_n = 1'b1;
    load  = '0;
    step();
    total++;
    if ({tick, clk_div, pending} !== 12'h000) begin
      bad++;
      $display("FAIL post_rst got t/c/p=%b/%b/%b exp=0000/0000/0000",
               tick, clk_div, pending);
    end
    en = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = '0;
    load  = '0;
    div   = '0;
    high  = '0;
    test_reset();
    test_basic();
    test_midload();
    test_wrapload();
    test_edges();
    test_en_drop();
    test_multi_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
